// File: rtl/baseball_pkg.sv
// baseball_pkg: count limits, widths, event-priority enum and LED helper shared by the scoreboard stages.
package baseball_pkg;

    localparam int MAX_STRIKES = 3;
    localparam int MAX_BALLS   = 4;
    localparam int STRIKE_W    = $clog2(MAX_STRIKES);
    localparam int BALL_W      = $clog2(MAX_BALLS);

    localparam logic [STRIKE_W-1:0] STRIKE_LAST = STRIKE_W'(MAX_STRIKES - 1);
    localparam logic [BALL_W-1:0]   BALL_LAST   = BALL_W'(MAX_BALLS - 1);

    typedef enum logic [2:0] {
        EV_NONE,
        EV_CHANGE,
        EV_PLAY,
        EV_STRIKE,
        EV_FOUL,
        EV_BALL
    } ev_e;

    // Active-low bar graph: bit k-1 is 0 when n >= k.
    function automatic logic [2:0] led_bar(input logic [1:0] n);
        return {n < 2'd3, n < 2'd2, n == 2'd0};
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// btn_edge_detect: SYNC_STAGES-flop synchronizer plus rising-edge detector for one button.
// Detection stays disarmed until the pipeline holds post-reset samples, so a held button is ignored.
module btn_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    localparam int FILL_W = 3;
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic                   armed;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn};
        prev_d = sync_q[SYNC_STAGES-1];
        armed  = fill_q == FILL_DONE;
        fill_d = armed ? fill_q : fill_q + 1'b1;
        rise   = armed & sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            fill_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/ball_strike_count.sv
// ball_strike_count: ball/strike counter with active-low LEDs and out/walk pulses.
// Foul handling is compiled in only when FOUL_EN is defined.
module ball_strike_count
    import baseball_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic strike_btn,
    input  logic ball_btn,
    input  logic foul_btn,
    input  logic play_btn,
    input  logic change_pulse,
    output logic strike1_led,
    output logic strike2_led,
    output logic ball1_led,
    output logic ball2_led,
    output logic ball3_led,
    output logic out_pulse,
    output logic walk_pulse
);

    logic strike_ev, ball_ev, play_ev, foul_ev;

    btn_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_strike (
        .clk(clk), .reset(reset), .btn(strike_btn), .rise(strike_ev));
    btn_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_ball (
        .clk(clk), .reset(reset), .btn(ball_btn), .rise(ball_ev));
    btn_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_play (
        .clk(clk), .reset(reset), .btn(play_btn), .rise(play_ev));

`ifdef FOUL_EN
    btn_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_foul (
        .clk(clk), .reset(reset), .btn(foul_btn), .rise(foul_ev));
`else
    logic unused_foul;
    assign unused_foul = foul_btn;
    assign foul_ev     = 1'b0;
`endif

    ev_e                 ev;
    logic [STRIKE_W-1:0] strikes_q, strikes_d;
    logic [BALL_W-1:0]   balls_q, balls_d;
    logic                out_q, out_d, walk_q, walk_d;
    logic [1:0]          s_led_q, s_led_d;
    logic [2:0]          b_led_q, b_led_d, s_bar;

    always_comb begin
        ev = change_pulse ? EV_CHANGE :
             play_ev      ? EV_PLAY   :
             strike_ev    ? EV_STRIKE :
             foul_ev      ? EV_FOUL   :
             ball_ev      ? EV_BALL   : EV_NONE;
        strikes_d = strikes_q;
        balls_d   = balls_q;
        out_d     = 1'b0;
        walk_d    = 1'b0;
        case (ev)
            EV_CHANGE, EV_PLAY: begin
                strikes_d = '0;
                balls_d   = '0;
            end
            EV_STRIKE: begin
                if (strikes_q == STRIKE_LAST) begin
                    strikes_d = '0;
                    balls_d   = '0;
                    out_d     = 1'b1;
                end else begin
                    strikes_d = strikes_q + 1'b1;
                end
            end
            EV_FOUL: begin
                if (strikes_q != STRIKE_LAST) strikes_d = strikes_q + 1'b1;
            end
            EV_BALL: begin
                if (balls_q == BALL_LAST) begin
                    strikes_d = '0;
                    balls_d   = '0;
                    walk_d    = 1'b1;
                end else begin
                    balls_d = balls_q + 1'b1;
                end
            end
            default: ;
        endcase
        s_bar   = led_bar(strikes_d);
        s_led_d = s_bar[1:0];
        b_led_d = led_bar(balls_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strikes_q <= '0;
            balls_q   <= '0;
            out_q     <= 1'b0;
            walk_q    <= 1'b0;
            s_led_q   <= '1;
            b_led_q   <= '1;
        end else begin
            strikes_q <= strikes_d;
            balls_q   <= balls_d;
            out_q     <= out_d;
            walk_q    <= walk_d;
            s_led_q   <= s_led_d;
            b_led_q   <= b_led_d;
        end
    end

    assign {strike2_led, strike1_led}       = s_led_q;
    assign {ball3_led, ball2_led, ball1_led} = b_led_q;
    assign out_pulse  = out_q;
    assign walk_pulse = walk_q;

endmodule

// File: tb/tb_ball_strike_count.sv
// tb_ball_strike_count: directed self-checking bench for ball_strike_count (default build, FOUL_EN optional).
module tb_ball_strike_count;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic strike_btn = 1'b0, ball_btn = 1'b0, foul_btn = 1'b0, play_btn = 1'b0, change_pulse = 1'b0;
    logic strike1_led, strike2_led, ball1_led, ball2_led, ball3_led, out_pulse, walk_pulse;

    ball_strike_count dut (
        .clk(clk), .reset(reset),
        .strike_btn(strike_btn), .ball_btn(ball_btn), .foul_btn(foul_btn),
        .play_btn(play_btn), .change_pulse(change_pulse),
        .strike1_led(strike1_led), .strike2_led(strike2_led),
        .ball1_led(ball1_led), .ball2_led(ball2_led), .ball3_led(ball3_led),
        .out_pulse(out_pulse), .walk_pulse(walk_pulse)
    );

    always #5 clk = ~clk;

    int cmp = 0;
    int errs = 0;

    wire [4:0] leds = {strike2_led, strike1_led, ball3_led, ball2_led, ball1_led};
    wire [1:0] pul  = {out_pulse, walk_pulse};

    // Expected active-low LED pattern {s2,s1,b3,b2,b1} for s strikes and b balls.
    function automatic logic [4:0] exp_leds(input int s, input int b);
        return {s < 2, s < 1, b < 3, b < 2, b < 1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int w, input logic v);
        case (w)
            0: strike_btn = v;
            1: ball_btn   = v;
            2: foul_btn   = v;
            default: play_btn = v;
        endcase
    endtask

    task automatic hit(input int w);
        set_btn(w, 1'b1);
        tick(); tick(); tick();
    endtask

    task automatic rel(input int w);
        set_btn(w, 1'b0);
        tick(); tick(); tick();
    endtask

    task automatic clear_count();
        change_pulse = 1'b1;
        tick();
        change_pulse = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        cmp++; if (leds !== 5'b11111) begin errs++; $display("FAIL reset_leds got %b want %b", leds, 5'b11111); end
        cmp++; if (pul !== 2'b00) begin errs++; $display("FAIL reset_pulses got %b want %b", pul, 2'b00); end
        reset = 1'b0;
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_strikeout();
        hit(0);
        cmp++; if (leds !== exp_leds(1, 0)) begin errs++; $display("FAIL so_1 got %b want %b", leds, exp_leds(1, 0)); end
        rel(0);
        hit(0);
        cmp++; if (leds !== exp_leds(2, 0)) begin errs++; $display("FAIL so_2 got %b want %b", leds, exp_leds(2, 0)); end
        cmp++; if (pul !== 2'b00) begin errs++; $display("FAIL so_2_pulse got %b want %b", pul, 2'b00); end
        rel(0);
        hit(0);
        cmp++; if (leds !== exp_leds(0, 0)) begin errs++; $display("FAIL so_3 got %b want %b", leds, exp_leds(0, 0)); end
        cmp++; if (pul !== 2'b10) begin errs++; $display("FAIL so_out got %b want %b", pul, 2'b10); end
        tick();
        cmp++; if (pul !== 2'b00) begin errs++; $display("FAIL so_out_width got %b want %b", pul, 2'b00); end
        rel(0);
    endtask

    task automatic test_walk();
        for (int n = 1; n <= 3; n++) begin
            hit(1);
            cmp++; if (leds !== exp_leds(0, n)) begin errs++; $display("FAIL walk_%0d got %b want %b", n, leds, exp_leds(0, n)); end
            rel(1);
        end
        hit(1);
        cmp++; if (leds !== exp_leds(0, 0)) begin errs++; $display("FAIL walk_4 got %b want %b", leds, exp_leds(0, 0)); end
        cmp++; if (pul !== 2'b01) begin errs++; $display("FAIL walk_pulse got %b want %b", pul, 2'b01); end
        tick();
        cmp++; if (pul !== 2'b00) begin errs++; $display("FAIL walk_width got %b want %b", pul, 2'b00); end
        rel(1);
    endtask

    task automatic test_foul();
`ifdef FOUL_EN
        hit(2); rel(2);
        cmp++; if (leds !== exp_leds(1, 0)) begin errs++; $display("FAIL foul_inc got %b want %b", leds, exp_leds(1, 0)); end
        hit(0); rel(0);
        for (int n = 0; n < 3; n++) begin
            hit(2);
            cmp++; if (leds !== exp_leds(2, 0) || pul !== 2'b00) begin errs++; $display("FAIL foul_at2_%0d got %b/%b want %b/00", n, leds, pul, exp_leds(2, 0)); end
            rel(2);
        end
        clear_count();
`else
        hit(2);
        cmp++; if (leds !== exp_leds(0, 0) || pul !== 2'b00) begin errs++; $display("FAIL foul_off got %b/%b want %b/00", leds, pul, exp_leds(0, 0)); end
        rel(2);
`endif
    endtask

    task automatic test_change_play();
        hit(1); rel(1);
        hit(0); rel(0);
        cmp++; if (leds !== exp_leds(1, 1)) begin errs++; $display("FAIL pre_change got %b want %b", leds, exp_leds(1, 1)); end
        clear_count();
        cmp++; if (leds !== exp_leds(0, 0) || pul !== 2'b00) begin errs++; $display("FAIL change got %b/%b want %b/00", leds, pul, exp_leds(0, 0)); end
        hit(0); rel(0);
        hit(3);
        cmp++; if (leds !== exp_leds(0, 0) || pul !== 2'b00) begin errs++; $display("FAIL play got %b/%b want %b/00", leds, pul, exp_leds(0, 0)); end
        rel(3);
    endtask

    task automatic test_simultaneous();
        hit(0); rel(0); hit(0); rel(0);
        hit(1); rel(1);
        strike_btn = 1'b1; ball_btn = 1'b1;
        tick(); tick(); tick();
        cmp++; if (leds !== exp_leds(0, 0) || pul !== 2'b10) begin errs++; $display("FAIL sim_sb got %b/%b want %b/10", leds, pul, exp_leds(0, 0)); end
        strike_btn = 1'b0; ball_btn = 1'b0;
        tick(); tick(); tick();
        cmp++; if (leds !== exp_leds(0, 0)) begin errs++; $display("FAIL sim_ball_dropped got %b want %b", leds, exp_leds(0, 0)); end
        hit(0); rel(0); hit(0); rel(0);
        hit(1); rel(1);
        strike_btn = 1'b1;
        tick(); tick();
        change_pulse = 1'b1;
        tick();
        change_pulse = 1'b0;
        cmp++; if (leds !== exp_leds(0, 0) || pul !== 2'b00) begin errs++; $display("FAIL sim_change got %b/%b want %b/00", leds, pul, exp_leds(0, 0)); end
        rel(0);
        cmp++; if (leds !== exp_leds(0, 0)) begin errs++; $display("FAIL sim_strike_dropped got %b want %b", leds, exp_leds(0, 0)); end
    endtask

    task automatic test_back_to_back();
        strike_btn = 1'b1;
        tick();
        ball_btn = 1'b1;
        tick(); tick();
        cmp++; if (leds !== exp_leds(1, 0)) begin errs++; $display("FAIL b2b_strike got %b want %b", leds, exp_leds(1, 0)); end
        tick();
        cmp++; if (leds !== exp_leds(1, 1)) begin errs++; $display("FAIL b2b_ball got %b want %b", leds, exp_leds(1, 1)); end
        strike_btn = 1'b0; ball_btn = 1'b0;
        tick(); tick(); tick();
        clear_count();
    endtask

    task automatic test_held();
        strike_btn = 1'b1;
        tick(); tick();
        cmp++; if (leds !== exp_leds(0, 0)) begin errs++; $display("FAIL held_early got %b want %b", leds, exp_leds(0, 0)); end
        tick();
        cmp++; if (leds !== exp_leds(1, 0)) begin errs++; $display("FAIL held_latency got %b want %b", leds, exp_leds(1, 0)); end
        repeat (47) tick();
        cmp++; if (leds !== exp_leds(1, 0)) begin errs++; $display("FAIL held_once got %b want %b", leds, exp_leds(1, 0)); end
        rel(0);
        cmp++; if (leds !== exp_leds(1, 0)) begin errs++; $display("FAIL held_release got %b want %b", leds, exp_leds(1, 0)); end
        clear_count();
    endtask

    task automatic test_reset_mid();
        hit(0); rel(0); hit(0); rel(0);
        strike_btn = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        cmp++; if (leds !== 5'b11111 || pul !== 2'b00) begin errs++; $display("FAIL rst_mid got %b/%b want 11111/00", leds, pul); end
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cmp++; if (leds !== 5'b11111 || pul !== 2'b00) begin errs++; $display("FAIL rst_after_%0d got %b/%b want 11111/00", i, leds, pul); end
        end
        rel(0);
        hit(0);
        cmp++; if (leds !== exp_leds(1, 0)) begin errs++; $display("FAIL rst_recover got %b want %b", leds, exp_leds(1, 0)); end
        rel(0);
    endtask

    initial begin
        test_reset();
        test_strikeout();
        test_walk();
        test_foul();
        test_change_play();
        test_simultaneous();
        test_back_to_back();
        test_held();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
